// File: rtl/dll_lock_detect_if.sv
`default_nettype none
// ============================================================================
// Module      : dll_lock_detect_if
// Description : Signal bundle between a monitored DLL and its lock detector.
//               master = the DLL side / stimulus, slave = the detector.
// Revision    : 1.0 - initial release
// ============================================================================
interface dll_lock_detect_if;
    logic [1:0] M;          // frequency-multiply select
    logic [3:0] N;          // divide/count setting
    logic       code_vld;   // new delay-line control word strobe
    logic [5:0] code;       // delay-line control word
    logic       lock;       // DLL declared locked
    logic       lock_lost;  // one-cycle pulse when lock falls
    logic [5:0] lock_code;  // code captured at lock
    logic [1:0] state;      // detector FSM state

    modport master (
        output M, N, code_vld, code,
        input  lock, lock_lost, lock_code, state
    );

    modport slave (
        input  M, N, code_vld, code,
        output lock, lock_lost, lock_code, state
    );
endinterface
`default_nettype wire

// File: rtl/dll_lock_detect.sv
`default_nettype none
// ============================================================================
// Module      : dll_lock_detect
// Description : Watches the delay-line control word of a DLL and declares
//               lock after LOCK_CNT consecutive small code updates; drops lock
//               after UNLOCK_CNT consecutive bad updates or a config change.
// Revision    : 1.0 - initial release
// ============================================================================
module dll_lock_detect #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 2,
    parameter int TOL        = 1,
    parameter int START_DLY  = 16
) (
    input  wire logic        clk_ext,
    input  wire logic        rst_n,
    dll_lock_detect_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACQ     = 2'b01,
        ST_LOCKED  = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam logic [7:0] c_SETTLE_LAST = 8'(START_DLY - 1);
    localparam logic [3:0] c_LOCK_CNT    = 4'(LOCK_CNT);
    localparam logic [3:0] c_UNLOCK_CNT  = 4'(UNLOCK_CNT);
    localparam logic [6:0] c_TOL         = 7'(TOL);
    localparam logic [5:0] c_RAIL_LO     = 6'd0;
    localparam logic [5:0] c_RAIL_HI     = 6'd63;

    // Registered state
    state_t     r_state;
    logic       r_lock;
    logic       r_lock_lost;
    logic [5:0] r_lock_code;
    logic [7:0] r_settle;
    logic [3:0] r_stable;
    logic [3:0] r_bad;
    logic [5:0] r_prev_code;
    logic       r_prev_ok;
    logic [1:0] r_m_q;
    logic [3:0] r_n_q;
    logic       r_cfg_armed;   // M_q/N_q hold valid history (not first cycle after reset)

    // Next-state values
    state_t     w_state_nxt;
    logic       w_lock_nxt;
    logic       w_lock_lost_nxt;
    logic [5:0] w_lock_code_nxt;
    logic [7:0] w_settle_nxt;
    logic [3:0] w_stable_nxt;
    logic [3:0] w_bad_nxt;
    logic [5:0] w_prev_code_nxt;
    logic       w_prev_ok_nxt;

    // Sample qualification
    logic       w_cfg_chg;
    logic       w_railed;
    logic [5:0] w_ref;
    logic [6:0] w_code_ext;
    logic [6:0] w_ref_ext;
    logic [6:0] w_delta;
    logic       w_good;
    logic [3:0] w_stable_inc;
    logic [3:0] w_bad_inc;

    assign w_cfg_chg  = r_cfg_armed && ((bus.M != r_m_q) || (bus.N != r_n_q));
    assign w_railed   = (bus.code == c_RAIL_LO) || (bus.code == c_RAIL_HI);

    // While locked the reference is frozen at the lock code; while acquiring
    // it tracks the previous sample.
    assign w_ref      = (r_state == ST_LOCKED) ? r_lock_code : r_prev_code;
    assign w_code_ext = {1'b0, bus.code};
    assign w_ref_ext  = {1'b0, w_ref};
    assign w_delta    = (w_code_ext >= w_ref_ext) ? (w_code_ext - w_ref_ext)
                                                  : (w_ref_ext - w_code_ext);
    assign w_good     = !w_railed && (w_delta <= c_TOL);

    assign w_stable_inc = (r_stable == 4'hF) ? r_stable : r_stable + 4'd1;
    assign w_bad_inc    = (r_bad == 4'hF)    ? r_bad    : r_bad + 4'd1;

    // Config history registers load every cycle
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_m_q       <= 2'd0;
            r_n_q       <= 4'd0;
            r_cfg_armed <= 1'b0;
        end else begin
            r_m_q       <= bus.M;
            r_n_q       <= bus.N;
            r_cfg_armed <= 1'b1;
        end
    end

    // FSM and datapath state register
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lock      <= 1'b0;
            r_lock_lost <= 1'b0;
            r_lock_code <= 6'd0;
            r_settle    <= 8'd0;
            r_stable    <= 4'd0;
            r_bad       <= 4'd0;
            r_prev_code <= 6'd0;
            r_prev_ok   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock      <= w_lock_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_lock_code <= w_lock_code_nxt;
            r_settle    <= w_settle_nxt;
            r_stable    <= w_stable_nxt;
            r_bad       <= w_bad_nxt;
            r_prev_code <= w_prev_code_nxt;
            r_prev_ok   <= w_prev_ok_nxt;
        end
    end

    // Next-state and output decode; a config change overrides any code sample
    always_comb begin
        w_state_nxt     = r_state;
        w_lock_nxt      = r_lock;
        w_lock_lost_nxt = 1'b0;
        w_lock_code_nxt = r_lock_code;
        w_settle_nxt    = r_settle;
        w_stable_nxt    = r_stable;
        w_bad_nxt       = r_bad;
        w_prev_code_nxt = r_prev_code;
        w_prev_ok_nxt   = r_prev_ok;

        if (r_state == ST_ILLEGAL) begin
            // Recover to the reset picture
            w_state_nxt     = ST_IDLE;
            w_lock_nxt      = 1'b0;
            w_lock_code_nxt = 6'd0;
            w_settle_nxt    = 8'd0;
            w_stable_nxt    = 4'd0;
            w_bad_nxt       = 4'd0;
            w_prev_code_nxt = 6'd0;
            w_prev_ok_nxt   = 1'b0;
        end else if (w_cfg_chg) begin
            w_state_nxt     = ST_IDLE;
            w_lock_nxt      = 1'b0;
            w_lock_lost_nxt = (r_state == ST_LOCKED);
            w_settle_nxt    = 8'd0;
            w_stable_nxt    = 4'd0;
            w_bad_nxt       = 4'd0;
            w_prev_ok_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_settle == c_SETTLE_LAST) begin
                        w_state_nxt  = ST_ACQ;
                        w_settle_nxt = 8'd0;
                    end else begin
                        w_settle_nxt = r_settle + 8'd1;
                    end
                end
                ST_ACQ: begin
                    if (bus.code_vld) begin
                        w_prev_code_nxt = bus.code;
                        if (!r_prev_ok) begin
                            // First sample only establishes the reference
                            w_prev_ok_nxt = 1'b1;
                        end else if (w_good) begin
                            w_stable_nxt = w_stable_inc;
                            if (w_stable_inc >= c_LOCK_CNT) begin
                                w_state_nxt     = ST_LOCKED;
                                w_lock_nxt      = 1'b1;
                                w_lock_code_nxt = bus.code;
                                w_bad_nxt       = 4'd0;
                            end
                        end else begin
                            w_stable_nxt = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bus.code_vld) begin
                        if (w_good) begin
                            w_bad_nxt = 4'd0;
                        end else if (w_bad_inc >= c_UNLOCK_CNT) begin
                            w_state_nxt     = ST_ACQ;
                            w_lock_nxt      = 1'b0;
                            w_lock_lost_nxt = 1'b1;
                            w_stable_nxt    = 4'd0;
                            w_bad_nxt       = 4'd0;
                            w_prev_ok_nxt   = 1'b0;
                        end else begin
                            w_bad_nxt = w_bad_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.lock      = r_lock;
    assign bus.lock_lost = r_lock_lost;
    assign bus.lock_code = r_lock_code;
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: doc/dll_lock_detect.md
DLL_LOCK_DETECT -- requirements
Module: dll_lock_detect

Interface
REQ-001 Parameter LOCK_CNT, default 8: consecutive good code updates required to declare lock (range 2..15).
REQ-002 Parameter UNLOCK_CNT, default 2: consecutive bad code updates required to drop lock (range 1..15).
REQ-003 Parameter TOL, default 1: maximum absolute code delta counted as good (range 0..7).
REQ-004 Parameter START_DLY, default 16: settle cycles after reset or config change before monitoring starts (range 1..255).
REQ-005 One clock, clk_ext; reset rst_n is asynchronous, active-low; all flops clear on rst_n=0, no synchronous reset.
REQ-006 clk_ext  input  1  reference clock; all logic on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 M  input  2  frequency-multiply select of the DLL being monitored.
REQ-009 N  input  4  divide/count setting of the DLL being monitored.
REQ-010 code_vld  input  1  single-cycle strobe: code holds a new delay-line control word.
REQ-011 code  input  6  delay-line control word (Q[5:0] of the DCDL).
REQ-012 lock  output  1  registered; 1 while the DLL is declared locked.
REQ-013 lock_lost  output  1  registered; one-cycle pulse when lock falls.
REQ-014 lock_code  output  6  registered; code captured when lock was declared.
REQ-015 state  output  2  registered FSM state: 00 IDLE, 01 ACQ, 10 LOCKED.

Function
REQ-016 M and N are registered every cycle into M_q/N_q; cfg_chg = (M != M_q) or (N != N_q); cfg_chg is never raised in the first cycle after reset (M_q/N_q load on that cycle).
REQ-017 IDLE: settle counter counts clk_ext cycles; on reaching START_DLY-1, next state ACQ; code_vld ignored in IDLE.
REQ-018 A sample is bad if code == 6'd0 or code == 6'd63 (delay line at rail), regardless of delta.
REQ-019 Delta = |code - ref|, computed at 7 bits, no wrap; good if delta <= TOL and not railed.
REQ-020 ACQ: ref = prev_code; first code_vld after entering ACQ only loads prev_code and sets prev_ok, without counting.
REQ-021 ACQ: on each code_vld with prev_ok, good increments stable_cnt, bad clears stable_cnt to 0; prev_code <= code in both cases.
REQ-022 ACQ: a good sample that brings stable_cnt to LOCK_CNT moves to LOCKED; lock=1 and lock_code=code on the following clock edge (latency 1 cycle from qualifying code_vld).
REQ-023 LOCKED: ref = lock_code (no tracking); good sample clears bad_cnt; bad sample increments bad_cnt.
REQ-024 LOCKED: bad sample that brings bad_cnt to UNLOCK_CNT goes to ACQ: lock=0, lock_lost=1 for exactly one cycle, stable_cnt=0, bad_cnt=0, prev_ok=0; lock_code keeps its last value.
REQ-025 cfg_chg in any state, next state IDLE, settle counter restarts at 0, all counters and prev_ok clear; if leaving LOCKED, lock=0 and lock_lost pulses once.
REQ-026 cfg_chg has priority over code_vld in the same cycle; that code sample is discarded.
REQ-027 Counters saturate; state encoding 11 is illegal and returns to IDLE next cycle with all outputs at reset values.
REQ-028 lock_lost never asserts twice on consecutive cycles; lock and lock_lost never both 1.

Reset
REQ-029 On rst_n=0: state=IDLE, lock=0, lock_lost=0, lock_code=0, all counters, prev_code, prev_ok, M_q, N_q = 0.
REQ-030 rst_n asserted mid-ACQ or mid-LOCKED clears immediately without a lock_lost pulse; after release, full START_DLY settle applies.

Verification
REQ-031 Reset release, M/N constant, code_vld every 4 cycles with code=30 -> state 01 after 16 cycles; 1 load + 8 good samples; lock=1 one cycle after 9th strobe, lock_code=30.
REQ-032 Locked at 30, codes 31,29,32,33 -> 31,29 good; 32 and 33 bad -> lock falls after 33, lock_lost single pulse, state=01.
REQ-033 ACQ with codes 20,21,20,24,25,... -> stable_cnt 1,2 then cleared at 24; lock requires 8 further good samples from 24.
REQ-034 Code stream stuck at 63 (or 0) -> lock never asserts; if locked, UNLOCK_CNT rail samples drop lock.
REQ-035 Locked; N changes 4->5 in same cycle as code_vld -> lock=0, lock_lost pulse, state=00, sample ignored, 16-cycle settle restarts.
REQ-036 Reset asserted while locked -> lock=0 asynchronously, lock_lost stays 0, lock_code=0.
